// File: rtl/audio_pkg.sv
// Shared definitions for the audio volume ramp: ramp FSM states, the mute code
// and the default symmetric output limit.
package audio_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // All-ones attenuation code; this code silences the channel instead of shifting.
  function automatic int mute_code(input int atten_bits);
    return (32'sd1 << atten_bits) - 32'sd1;
  endfunction

  function automatic int default_limit(input int width);
    return (32'sd1 << (width - 32'sd1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/audio_atten_channel.sv
// One channel of the volume stage: arithmetic-shift attenuation, mute and a
// symmetric clamp. Purely combinational; the top level registers the result.
module audio_atten_channel
  import audio_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ATTEN_BITS = 3,
  parameter int LIMIT      = default_limit(WIDTH)
) (
  input  logic signed [WIDTH-1:0]      sample,
  input  logic        [ATTEN_BITS-1:0] atten,
  output logic signed [WIDTH-1:0]      result
);

  localparam logic [ATTEN_BITS-1:0] MUTE    = ATTEN_BITS'(mute_code(ATTEN_BITS));
  localparam logic signed [WIDTH:0] LIM_POS = (WIDTH + 1)'(LIMIT);
  localparam logic signed [WIDTH:0] LIM_NEG = -LIM_POS;

  logic signed [WIDTH-1:0] shifted_s;
  logic signed [WIDTH:0]   wide_s;

  // Shift, then compare one bit wider so the negative limit never overflows.
  always_comb begin
    shifted_s = sample >>> atten;
    wide_s    = {shifted_s[WIDTH-1], shifted_s};
    if (atten == MUTE) begin
      result = {WIDTH{1'b0}};
    end else if (wide_s > LIM_POS) begin
      result = LIM_POS[WIDTH-1:0];
    end else if (wide_s < LIM_NEG) begin
      result = LIM_NEG[WIDTH-1:0];
    end else begin
      result = shifted_s;
    end
  end

endmodule

// File: rtl/audio_volume_ramp.sv
// Multi-channel volume stage: attenuation ramps one code per RAMP_DIV sample
// strobes toward the requested level (mute included), outputs are registered.
module audio_volume_ramp
  import audio_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 2,
  parameter int ATTEN_BITS = 3,
  parameter int RAMP_DIV   = 64,
  parameter int LIMIT      = default_limit(WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_valid_in,
  input  logic [CHANNELS*WIDTH-1:0]   audio_in,
  input  logic [ATTEN_BITS-1:0]       volume_ctrl,
  input  logic                        mute,
  output logic [CHANNELS*WIDTH-1:0]   audio_out,
  output logic                        sample_valid_out,
  output logic                        ramp_busy
);

  localparam logic [ATTEN_BITS-1:0] MUTE = ATTEN_BITS'(mute_code(ATTEN_BITS));
  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  ramp_state_t                 state_r;
  ramp_state_t                 state_nxt_s;
  logic [CNT_W-1:0]            cnt_r;
  logic [CNT_W-1:0]            cnt_nxt_s;
  logic [ATTEN_BITS-1:0]       cur_atten_r;
  logic [ATTEN_BITS-1:0]       atten_nxt_s;
  logic [ATTEN_BITS-1:0]       target_s;
  logic [CHANNELS*WIDTH-1:0]   processed_s;
  logic [CHANNELS*WIDTH-1:0]   audio_out_r;
  logic                        valid_out_r;

  assign target_s = mute ? MUTE : volume_ctrl;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    audio_atten_channel #(
      .WIDTH      (WIDTH),
      .ATTEN_BITS (ATTEN_BITS),
      .LIMIT      (LIMIT)
    ) u_chan (
      .sample (audio_in[ch*WIDTH +: WIDTH]),
      .atten  (cur_atten_r),
      .result (processed_s[ch*WIDTH +: WIDTH])
    );
  end

  // Next-state logic: the counter only advances on strobes while ramping.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    atten_nxt_s = cur_atten_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (cur_atten_r != target_s) begin
          state_nxt_s = RAMP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RAMP: begin
        if (cur_atten_r == target_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (sample_valid_in) begin
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (target_s > cur_atten_r) begin
              atten_nxt_s = cur_atten_r + ATTEN_BITS'(1);
            end else begin
              atten_nxt_s = cur_atten_r - ATTEN_BITS'(1);
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Ramp state, counter and current attenuation; reset restarts the fade-in from mute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      cur_atten_r <= MUTE;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      cur_atten_r <= atten_nxt_s;
    end
  end

  // Output register samples with the pre-step attenuation and holds between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_out_r <= {(CHANNELS*WIDTH){1'b0}};
      valid_out_r <= 1'b0;
    end else begin
      valid_out_r <= sample_valid_in;
      if (sample_valid_in) begin
        audio_out_r <= processed_s;
      end
    end
  end

  assign audio_out        = audio_out_r;
  assign sample_valid_out = valid_out_r;
  assign ramp_busy        = (state_r == RAMP);

endmodule

// File: tb/tb_audio_volume_ramp.sv
// Directed self-checking bench for audio_volume_ramp with RAMP_DIV=4, 16-bit stereo.
module tb_audio_volume_ramp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid_in = 1'b0;
  logic [31:0] audio_in = 32'd0;
  logic [2:0]  volume_ctrl = 3'd0;
  logic        mute = 1'b0;
  logic [31:0] audio_out;
  logic        sample_valid_out;
  logic        ramp_busy;

  int checks = 0;
  int errors = 0;

  audio_volume_ramp #(
    .WIDTH      (16),
    .CHANNELS   (2),
    .ATTEN_BITS (3),
    .RAMP_DIV   (4),
    .LIMIT      (32767)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_valid_in  (sample_valid_in),
    .audio_in         (audio_in),
    .volume_ctrl      (volume_ctrl),
    .mute             (mute),
    .audio_out        (audio_out),
    .sample_valid_out (sample_valid_out),
    .ramp_busy        (ramp_busy)
  );

  always #5 clk = ~clk;

  // One-cycle strobe; returns 1 time unit after the capturing edge.
  task automatic drive_strobe(input logic [15:0] l, input logic [15:0] r);
    @(posedge clk); #1;
    audio_in = {r, l};
    sample_valid_in = 1'b1;
    @(posedge clk); #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic gap();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    volume_ctrl = 3'd0;
    mute = 1'b0;
    #2;
    checks++; if (audio_out !== 32'd0) begin errors++; $display("FAIL reset_out got %h exp %h", audio_out, 32'd0); end
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sample_valid_out); end
    checks++; if (ramp_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ramp_busy); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (ramp_busy !== 1'b1) begin errors++; $display("FAIL first_compare_busy got %b exp 1", ramp_busy); end
  endtask

  task automatic test_fade_in(input int n);
    for (int k = 1; k <= n; k++) begin
      int cur;
      logic [15:0] e;
      logic exp_busy;
      cur = 7 - (k - 1) / 4;
      if (cur < 0) cur = 0;
      e = (cur == 7) ? 16'h0000 : (16'h4000 >> cur);
      exp_busy = (k <= 28);
      drive_strobe(16'h4000, 16'h4000);
      checks++; if (audio_out !== {e, e}) begin errors++; $display("FAIL fade_in_%0d got %h exp %h", k, audio_out, {e, e}); end
      checks++; if (ramp_busy !== exp_busy) begin errors++; $display("FAIL fade_busy_%0d got %b exp %b", k, ramp_busy, exp_busy); end
      checks++; if (sample_valid_out !== 1'b1) begin errors++; $display("FAIL fade_valid_%0d got %b exp 1", k, sample_valid_out); end
      gap();
    end
  endtask

  task automatic test_limits();
    logic [31:0] e;
    drive_strobe(16'h8000, 16'h7fff);
    checks++; if (audio_out !== 32'h7fff_8001) begin errors++; $display("FAIL clamp_neg got %h exp %h", audio_out, 32'h7fff_8001); end
    gap();
    volume_ctrl = 3'd1;
    for (int k = 1; k <= 5; k++) begin
      e = (k <= 4) ? 32'h7fff_8001 : 32'h3fff_c000;
      drive_strobe(16'h8000, 16'h7fff);
      checks++; if (audio_out !== e) begin errors++; $display("FAIL limits_%0d got %h exp %h", k, audio_out, e); end
      gap();
    end
  endtask

  task automatic test_mute_ramp();
    volume_ctrl = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      drive_strobe(16'h4000, 16'h4000);
      gap();
    end
    mute = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      int cur;
      logic [15:0] e;
      cur = (k - 1) / 4;
      e = (cur >= 7) ? 16'h0000 : (16'h4000 >> cur);
      drive_strobe(16'h4000, 16'h4000);
      checks++; if (audio_out !== {e, e}) begin errors++; $display("FAIL mute_%0d got %h exp %h", k, audio_out, {e, e}); end
      checks++; if (sample_valid_out !== 1'b1) begin errors++; $display("FAIL mute_valid_%0d got %b exp 1", k, sample_valid_out); end
      if (k <= 28) begin
        checks++; if (ramp_busy !== 1'b1) begin errors++; $display("FAIL mute_busy_%0d got %b exp 1", k, ramp_busy); end
      end
      @(posedge clk); #1;
      checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL mute_valid_fall_%0d got %b exp 0", k, sample_valid_out); end
      @(posedge clk);
    end
  endtask

  task automatic test_reversal();
    logic [15:0] e;
    mute = 1'b0;
    volume_ctrl = 3'd0;
    for (int k = 1; k <= 28; k++) begin
      drive_strobe(16'h4000, 16'h4000);
      gap();
    end
    mute = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      drive_strobe(16'h4000, 16'h4000);
      if (k >= 13) begin
        checks++; if (audio_out !== 32'h0800_0800) begin errors++; $display("FAIL rev_setup_%0d got %h exp %h", k, audio_out, 32'h0800_0800); end
      end
      gap();
    end
    mute = 1'b0;
    volume_ctrl = 3'd1;
    for (int k = 15; k <= 21; k++) begin
      e = (k <= 16) ? 16'h0800 : ((k <= 20) ? 16'h1000 : 16'h2000);
      drive_strobe(16'h4000, 16'h4000);
      checks++; if (audio_out !== {e, e}) begin errors++; $display("FAIL reversal_%0d got %h exp %h", k, audio_out, {e, e}); end
      checks++; if (ramp_busy !== (k <= 20)) begin errors++; $display("FAIL rev_busy_%0d got %b exp %b", k, ramp_busy, (k <= 20)); end
      gap();
    end
  endtask

  task automatic test_no_strobe();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      volume_ctrl = 3'(i);
      mute = (i % 5 == 0);
      checks++; if (audio_out !== 32'h2000_2000) begin errors++; $display("FAIL hold_out_%0d got %h exp %h", i, audio_out, 32'h2000_2000); end
      checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL hold_valid_%0d got %b exp 0", i, sample_valid_out); end
    end
    @(negedge clk);
    volume_ctrl = 3'd1;
    mute = 1'b0;
    repeat (2) @(posedge clk);
    drive_strobe(16'h4000, 16'h4000);
    checks++; if (audio_out !== 32'h2000_2000) begin errors++; $display("FAIL hold_atten got %h exp %h", audio_out, 32'h2000_2000); end
    gap();
  endtask

  task automatic test_reset_mid_ramp();
    mute = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      drive_strobe(16'h4000, 16'h4000);
      if (k < 13) gap();
    end
    checks++; if (audio_out !== 32'h0400_0400) begin errors++; $display("FAIL pre_reset got %h exp %h", audio_out, 32'h0400_0400); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (audio_out !== 32'd0) begin errors++; $display("FAIL async_reset_out got %h exp %h", audio_out, 32'd0); end
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b exp 0", sample_valid_out); end
    checks++; if (ramp_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b exp 0", ramp_busy); end
    mute = 1'b0;
    volume_ctrl = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    test_fade_in(8);
  endtask

  initial begin
    test_reset();
    test_fade_in(32);
    test_limits();
    test_mute_ramp();
    test_reversal();
    test_no_strobe();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
